// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared HDC encoder constants, types and per-channel rotation table
package enc_pkg;
  localparam int HV_DIM = 16;
  localparam int SH_W   = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;

  typedef logic [HV_DIM-1:0] hv_t;

  localparam int NUM_SHIFTS = 12;
  localparam int SHIFTS [0:NUM_SHIFTS-1] = '{0, 1, 3, 15, 17, 5, 9, 30, 2, 11, 7, 22};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} binder_state_t;
endpackage

// File: rtl/enc_rot_lane.sv
// rtl/enc_rot_lane.sv - combinational cyclic rotator, dir 0 = left (bind), 1 = right (unbind)
module enc_rot_lane
  import enc_pkg::*;
(
  input  logic [HV_DIM-1:0] hv,
  input  logic [SH_W-1:0]   shift,
  input  logic              dir,
  output logic [HV_DIM-1:0] rot_hv
);

  logic [2*HV_DIM-1:0] w_dbl;

  // A left rotate by s is a right rotate by HV_DIM-s of the doubled word; s=0 falls out as passthrough.
  always_comb begin
    w_dbl  = {hv, hv};
    rot_hv = dir ? hv_t'(w_dbl >> shift) : hv_t'(w_dbl >> (HV_DIM - int'(shift)));
  end

endmodule

// File: rtl/enc_binder_pack_tdm.sv
// rtl/enc_binder_pack_tdm.sv - time-multiplexed binder pack: LANES rotators reused over NBEATS beats
module enc_binder_pack_tdm
  import enc_pkg::*;
#(
  parameter int NUM_CH   = 10,
  parameter int LANES    = 2,
  parameter int BASE_IDX = 0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_encoding,
  input  logic              unbind,
  input  logic [HV_DIM-1:0] level_hv   [0:NUM_CH-1],
  output logic [HV_DIM-1:0] shifted_hv [0:NUM_CH-1],
  output logic              busy,
  output logic              done
);

  localparam int NBEATS = (NUM_CH + LANES - 1) / LANES;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  if (LANES < 1 || LANES > NUM_CH || BASE_IDX + NUM_CH > NUM_SHIFTS) begin : g_param_err
    $error("enc_binder_pack_tdm: invalid LANES/NUM_CH/BASE_IDX combination");
  end

  binder_state_t     r_state, w_state_nxt;
  logic [BEAT_W-1:0] r_beat, w_beat_nxt;
  logic              r_mode, w_mode_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  hv_t               r_shifted [NUM_CH];
  hv_t               w_lane_out [LANES];

  function automatic logic [SH_W-1:0] ch_shift(input int ch);
    return SH_W'(SHIFTS[BASE_IDX + ch] % HV_DIM);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_mode_nxt  = r_mode;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_encoding) begin
          w_state_nxt = RUN;
          w_beat_nxt  = '0;
          w_mode_nxt  = unbind;
          w_busy_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (r_beat == LAST_BEAT) begin
          w_state_nxt = IDLE;
          w_beat_nxt  = '0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_beat_nxt = r_beat + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Lane l serves channels l, l+LANES, ...; the current beat picks which one feeds the rotator.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    hv_t             w_in;
    logic [SH_W-1:0] w_sh;

    always_comb begin
      w_in = '0;
      w_sh = '0;
      for (int c = l; c < NUM_CH; c += LANES) begin
        if (r_beat == BEAT_W'(c / LANES)) begin
          w_in = level_hv[c];
          w_sh = ch_shift(c);
        end
      end
    end

    enc_rot_lane u_rot (
      .hv     (w_in),
      .shift  (w_sh),
      .dir    (r_mode),
      .rot_hv (w_lane_out[l])
    );
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) r_shifted[c] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_mode  <= w_mode_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (r_state == RUN) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (r_beat == BEAT_W'(c / LANES)) r_shifted[c] <= w_lane_out[c % LANES];
        end
      end
    end
  end

  assign shifted_hv = r_shifted;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_enc_binder_pack_tdm.sv
// tb/tb_enc_binder_pack_tdm.sv - bench for enc_binder_pack_tdm with LANES=2, 1 and 5 instances
module tb_enc_binder_pack_tdm;
  import enc_pkg::*;

  localparam int NCH = 5;

  logic clk = 1'b0;
  logic nrst;
  logic unbind;
  logic start_v [3];
  hv_t  level_hv [NCH];
  hv_t  sh0 [NCH];
  hv_t  sh1 [NCH];
  hv_t  sh2 [NCH];
  logic busy0, busy1, busy2, done0, done1, done2;

  int   errors = 0;
  int   checks = 0;
  int   tb_shifts [NCH] = '{0, 1, 3, 15, 17};
  int   lanes_of [3] = '{2, 1, 5};
  hv_t  exp_q [3][NCH];
  hv_t  c_bind [NCH] = '{16'h0001, 16'h0002, 16'h0008, 16'h8000, 16'h0002};
  hv_t  c_unbind [NCH] = '{16'h0001, 16'h8000, 16'h2000, 16'h0002, 16'h8000};

  always #5 clk = ~clk;

  enc_binder_pack_tdm #(.NUM_CH(NCH), .LANES(2), .BASE_IDX(0)) u_dut2 (
    .clk(clk), .nrst(nrst), .start_encoding(start_v[0]), .unbind(unbind),
    .level_hv(level_hv), .shifted_hv(sh0), .busy(busy0), .done(done0));
  enc_binder_pack_tdm #(.NUM_CH(NCH), .LANES(1), .BASE_IDX(0)) u_dut1 (
    .clk(clk), .nrst(nrst), .start_encoding(start_v[1]), .unbind(unbind),
    .level_hv(level_hv), .shifted_hv(sh1), .busy(busy1), .done(done1));
  enc_binder_pack_tdm #(.NUM_CH(NCH), .LANES(5), .BASE_IDX(0)) u_dut5 (
    .clk(clk), .nrst(nrst), .start_encoding(start_v[2]), .unbind(unbind),
    .level_hv(level_hv), .shifted_hv(sh2), .busy(busy2), .done(done2));

  function automatic hv_t get_out(input int inst, input int ch);
    case (inst)
      0: return sh0[ch];
      1: return sh1[ch];
      default: return sh2[ch];
    endcase
  endfunction

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? busy0 : (inst == 1) ? busy1 : busy2;
  endfunction

  function automatic logic get_done(input int inst);
    return (inst == 0) ? done0 : (inst == 1) ? done1 : done2;
  endfunction

  // Reference rotation: bit i moves s places toward the MSB (bind) or toward the LSB (unbind).
  function automatic hv_t rot_model(input hv_t v, input int s, input bit right);
    hv_t r;
    for (int i = 0; i < HV_DIM; i++) begin
      if (!right) r[(i + s) % HV_DIM] = v[i];
      else        r[i] = v[(i + s) % HV_DIM];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_reset(input string tag);
    for (int inst = 0; inst < 3; inst++) begin
      chk($sformatf("%s busy i%0d", tag, inst), 16'(get_busy(inst)), 16'h0);
      chk($sformatf("%s done i%0d", tag, inst), 16'(get_done(inst)), 16'h0);
      for (int ch = 0; ch < NCH; ch++)
        chk($sformatf("%s out i%0d ch%0d", tag, inst, ch), get_out(inst, ch), 16'h0);
    end
  endtask

  // Caller is between edges; returns at the sample point where done is expected high.
  task automatic run(input string tag, input int inst, input bit mode, input bit poke);
    int  lanes;
    int  nb;
    hv_t nw [NCH];
    lanes = lanes_of[inst];
    nb = (NCH + lanes - 1) / lanes;
    for (int ch = 0; ch < NCH; ch++) nw[ch] = rot_model(level_hv[ch], tb_shifts[ch] % HV_DIM, mode);
    unbind = mode;
    start_v[inst] = 1'b1;
    for (int k = 0; k <= nb; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s busy k%0d", tag, k), 16'(get_busy(inst)), 16'(k < nb));
      chk($sformatf("%s done k%0d", tag, k), 16'(get_done(inst)), 16'(k == nb));
      for (int ch = 0; ch < NCH; ch++)
        chk($sformatf("%s ch%0d k%0d", tag, ch, k), get_out(inst, ch),
            (ch / lanes < k) ? nw[ch] : exp_q[inst][ch]);
      start_v[inst] = poke && (k < 2);
      unbind = (poke && k < 2) ? ~mode : mode;
    end
    start_v[inst] = 1'b0;
    for (int ch = 0; ch < NCH; ch++) exp_q[inst][ch] = nw[ch];
  endtask

  task automatic chk_quiet(input string tag, input int inst);
    @(negedge clk);
    chk({tag, " done low"}, 16'(get_done(inst)), 16'h0);
    chk({tag, " busy low"}, 16'(get_busy(inst)), 16'h0);
  endtask

  initial begin
    nrst = 1'b0;
    unbind = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    for (int ch = 0; ch < NCH; ch++) level_hv[ch] = '0;
    for (int i = 0; i < 3; i++) for (int ch = 0; ch < NCH; ch++) exp_q[i][ch] = '0;
    @(negedge clk);
    @(negedge clk);
    chk_all_reset("reset");
    nrst = 1'b1;
    @(negedge clk);

    // Case 1: bind of 0001 on every channel
    for (int ch = 0; ch < NCH; ch++) level_hv[ch] = 16'h0001;
    run("t1", 0, 1'b0, 1'b0);
    for (int ch = 0; ch < NCH; ch++) chk($sformatf("t1 const ch%0d", ch), sh0[ch], c_bind[ch]);
    chk_quiet("t1", 0);

    // Case 2: unbind, then unbind of the bound vectors restores the input
    run("t2", 0, 1'b1, 1'b0);
    for (int ch = 0; ch < NCH; ch++) chk($sformatf("t2 const ch%0d", ch), sh0[ch], c_unbind[ch]);
    for (int ch = 0; ch < NCH; ch++) level_hv[ch] = c_bind[ch];
    run("t2fb", 0, 1'b1, 1'b0);
    for (int ch = 0; ch < NCH; ch++) chk($sformatf("t2fb ch%0d", ch), sh0[ch], 16'h0001);
    chk_quiet("t2", 0);

    // Case 4: starts while busy are ignored; a start coincident with done is accepted
    for (int ch = 0; ch < NCH; ch++) level_hv[ch] = hv_t'($urandom);
    run("t4poke", 0, 1'($urandom), 1'b1);
    run("t4chain", 0, 1'($urandom), 1'b0);
    chk_quiet("t4", 0);

    // Case 5: reset in the middle of a run
    for (int ch = 0; ch < NCH; ch++) level_hv[ch] = hv_t'($urandom) | 16'h0101;
    unbind = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 nrst = 1'b0;
    #1 chk_all_reset("t5 async");
    for (int i = 0; i < 3; i++) for (int ch = 0; ch < NCH; ch++) exp_q[i][ch] = '0;
    @(negedge clk);
    chk("t5 hold done", 16'(done0), 16'h0);
    @(negedge clk);
    chk("t5 hold done2", 16'(done0), 16'h0);
    nrst = 1'b1;
    @(negedge clk);
    chk("t5 after release done", 16'(done0), 16'h0);
    for (int ch = 0; ch < NCH; ch++) level_hv[ch] = 16'h0001;
    run("t5rerun", 0, 1'b0, 1'b0);
    for (int ch = 0; ch < NCH; ch++) chk($sformatf("t5 const ch%0d", ch), sh0[ch], c_bind[ch]);
    chk_quiet("t5", 0);

    // Case 6: LANES=1 and LANES=5 give the same vectors with 5-beat and 1-beat latency
    run("t6l1", 1, 1'b0, 1'b0);
    for (int ch = 0; ch < NCH; ch++) chk($sformatf("t6l1 const ch%0d", ch), sh1[ch], c_bind[ch]);
    chk_quiet("t6l1", 1);
    run("t6l5", 2, 1'b0, 1'b0);
    for (int ch = 0; ch < NCH; ch++) chk($sformatf("t6l5 const ch%0d", ch), sh2[ch], c_bind[ch]);
    chk_quiet("t6l5", 2);

    // Random runs across all three configurations
    for (int i = 0; i < 9; i++) begin
      for (int ch = 0; ch < NCH; ch++) level_hv[ch] = hv_t'($urandom);
      run($sformatf("rnd%0d", i), i % 3, 1'($urandom), 1'b0);
      if (($urandom & 1) == 1) @(negedge clk);
    end
    @(negedge clk);
    for (int inst = 0; inst < 3; inst++)
      for (int ch = 0; ch < NCH; ch++)
        chk($sformatf("final i%0d ch%0d", inst, ch), get_out(inst, ch), exp_q[inst][ch]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
